// File: rtl/roulette_spinner_pkg.sv
// Shared definitions for the LED roulette: FSM states, 7-segment constants and LFSR step.
package roulette_spinner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPIN  = 2'd1,
        ST_DECEL = 2'd2,
        ST_SHOW  = 2'd3
    } state_e;

    localparam logic [6:0]  SEG_BLANK = 7'h7F;
    localparam logic [6:0]  SEG_DASH  = 7'h3F;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // One step of the 16-bit Galois LFSR (right-shifting form)
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        lfsr_next = s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

endpackage

// File: rtl/roulette_spinner_seg7_hex_dec.sv
// 4-bit value to active-low 7-segment glyph {g,f,e,d,c,b,a}; shared by display blocks.
module seg7_hex_dec
    import roulette_spinner_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_c_o
);

    always_comb begin
        seg_c_o = SEG_BLANK;
        unique case (hex_i)
            4'h0: seg_c_o = 7'h40;
            4'h1: seg_c_o = 7'h79;
            4'h2: seg_c_o = 7'h24;
            4'h3: seg_c_o = 7'h30;
            4'h4: seg_c_o = 7'h19;
            4'h5: seg_c_o = 7'h12;
            4'h6: seg_c_o = 7'h02;
            4'h7: seg_c_o = 7'h78;
            4'h8: seg_c_o = 7'h00;
            4'h9: seg_c_o = 7'h10;
            4'hA: seg_c_o = 7'h08;
            4'hB: seg_c_o = 7'h03;
            4'hC: seg_c_o = 7'h46;
            4'hD: seg_c_o = 7'h21;
            4'hE: seg_c_o = 7'h06;
            4'hF: seg_c_o = 7'h0E;
            default: seg_c_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/roulette_spinner.sv
// LED roulette: one lit LED circles N_LEDS positions; releasing run freezes it or
// decelerates it to a stop, and the stopped index is shown on HEX0.
module roulette_spinner
    import roulette_spinner_pkg::*;
#(
    parameter int unsigned N_LEDS    = 4,
    parameter int unsigned STEP_DIV  = 2_500_000,
    parameter int unsigned DECEL_INC = 500_000,
    parameter int unsigned STOP_DIV  = 25_000_000,
    parameter bit          JITTER_EN = 1'b1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              CLOCK_50,
    input  logic              nrst,
    input  logic [1:0]        SW,
    output logic [N_LEDS-1:0] LEDR,
    output logic [6:0]        HEX0
);

    localparam int unsigned PW = ($clog2(N_LEDS) > 1) ? $clog2(N_LEDS) : 1;
    localparam int unsigned CW = $clog2(STOP_DIV + DECEL_INC + 257);
    localparam int unsigned NW = CW + 1;

    logic [1:0]        sw_meta_q, sw_sync_q;
    logic              run_r_q;
    state_e            state_q, state_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     period_q, period_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [N_LEDS-1:0] ledr_q, ledr_d;
    logic [6:0]        hex_q, hex_d;

    logic              run_s, mode_s, run_rise, run_fall, step;
    logic [PW-1:0]     pos_inc;
    logic [NW-1:0]     np;
    logic [6:0]        glyph_c;

    seg7_hex_dec u_seg7 (
        .hex_i   (4'(pos_d)),
        .seg_c_o (glyph_c)
    );

    always_ff @(posedge CLOCK_50 or negedge nrst) begin
        if (!nrst) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            run_r_q   <= 1'b0;
            state_q   <= ST_IDLE;
            pos_q     <= '0;
            cnt_q     <= '0;
            period_q  <= CW'(STEP_DIV);
            lfsr_q    <= LFSR_SEED;
            ledr_q    <= '0;
            hex_q     <= SEG_BLANK;
        end else begin
            sw_meta_q <= SW;
            sw_sync_q <= sw_meta_q;
            run_r_q   <= sw_sync_q[1];
            state_q   <= state_d;
            pos_q     <= pos_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            lfsr_q    <= lfsr_d;
            ledr_q    <= ledr_d;
            hex_q     <= hex_d;
        end
    end

    // Next-state, timer and output-register inputs; a step always lands before any transition
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        lfsr_d   = lfsr_next(lfsr_q);
        ledr_d   = '0;
        hex_d    = SEG_BLANK;

        run_s    = sw_sync_q[1];
        mode_s   = sw_sync_q[0];
        run_rise = run_s & ~run_r_q;
        run_fall = ~run_s & run_r_q;
        step     = (cnt_q == period_q - CW'(1));
        pos_inc  = (pos_q == PW'(N_LEDS - 1)) ? '0 : pos_q + PW'(1);
        np       = NW'(period_q) + NW'(DECEL_INC)
                 + (JITTER_EN ? NW'(lfsr_q[7:0]) : NW'(0));

        unique case (state_q)
            ST_IDLE, ST_SHOW: begin
                if (run_rise) begin
                    state_d  = ST_SPIN;
                    cnt_d    = '0;
                    period_d = CW'(STEP_DIV);
                end
            end
            ST_SPIN: begin
                if (step) begin
                    pos_d = pos_inc;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (run_fall) begin
                    state_d = mode_s ? ST_DECEL : ST_SHOW;
                    cnt_d   = '0;
                end
            end
            ST_DECEL: begin
                if (step) begin
                    pos_d = pos_inc;
                    cnt_d = '0;
                    if (np >= NW'(STOP_DIV)) begin
                        state_d = ST_SHOW;
                    end else begin
                        period_d = CW'(np);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        for (int unsigned i = 0; i < N_LEDS; i++) begin
            ledr_d[i] = (state_d != ST_IDLE) && (pos_d == PW'(i));
        end

        unique case (state_d)
            ST_SPIN, ST_DECEL: hex_d = SEG_DASH;
            ST_SHOW:           hex_d = glyph_c;
            default:           hex_d = SEG_BLANK;
        endcase
    end

    assign LEDR = ledr_q;
    assign HEX0 = hex_q;

endmodule

// File: tb/tb_roulette_spinner.sv
// Bench for roulette_spinner: directed vector table, reset corners, then randomized runs
// on a deterministic and a jittered instance checked against an arithmetic model.
module tb_roulette_spinner;

    localparam int N    = 6;
    localparam int STEP = 4;
    localparam int DEC  = 2;
    localparam int STOP = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         nrst, nrst_j;
    logic [1:0]   sw, sw_j;
    logic [N-1:0] led, led_j;
    logic [6:0]   hex, hex_j;

    roulette_spinner #(.N_LEDS(N), .STEP_DIV(STEP), .DECEL_INC(DEC), .STOP_DIV(STOP),
                       .JITTER_EN(1'b0), .LFSR_SEED(16'hACE1)) dut (
        .CLOCK_50(clk), .nrst(nrst), .SW(sw), .LEDR(led), .HEX0(hex));

    roulette_spinner #(.N_LEDS(N), .STEP_DIV(STEP), .DECEL_INC(DEC), .STOP_DIV(STOP),
                       .JITTER_EN(1'b1), .LFSR_SEED(16'hACE1)) dut_j (
        .CLOCK_50(clk), .nrst(nrst_j), .SW(sw_j), .LEDR(led_j), .HEX0(hex_j));

    typedef struct {
        logic [1:0]   sw;
        int           ticks;
        logic [N-1:0] led;
        logic [6:0]   hex;
    } vec_t;

    vec_t vq[$];
    int   mgap[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void add(input logic [1:0] s, input int t,
                                input logic [N-1:0] l, input logic [6:0] h);
        vec_t v;
        v.sw = s; v.ticks = t; v.led = l; v.hex = h;
        vq.push_back(v);
    endfunction

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: glyph = 7'h40;  1: glyph = 7'h79;  2: glyph = 7'h24;  3: glyph = 7'h30;
            4: glyph = 7'h19;  5: glyph = 7'h12;  6: glyph = 7'h02;  7: glyph = 7'h78;
            8: glyph = 7'h00;  9: glyph = 7'h10; 10: glyph = 7'h08; 11: glyph = 7'h03;
           12: glyph = 7'h46; 13: glyph = 7'h21; 14: glyph = 7'h06; default: glyph = 7'h0E;
        endcase
    endfunction

    function automatic logic [N-1:0] oh(input int p);
        oh = '0;
        oh[p] = 1'b1;
    endfunction

    function automatic logic [N-1:0] get_led(input int k);
        get_led = (k == 0) ? led : led_j;
    endfunction

    function automatic logic [6:0] get_hex(input int k);
        get_hex = (k == 0) ? hex : hex_j;
    endfunction

    initial begin
        int per, nxt;
        int ps[2];

        // Deterministic decel gaps straight from the period rule
        per = STEP;
        forever begin
            mgap.push_back(per);
            nxt = per + DEC;
            if (nxt >= STOP) break;
            per = nxt;
        end

        // Spin up, wrap, instant stop, resume
        add(2'b10, 2, 6'b000000, 7'h7F);
        add(2'b10, 1, 6'b000001, 7'h3F);
        add(2'b10, 3, 6'b000001, 7'h3F);
        add(2'b10, 1, 6'b000010, 7'h3F);
        add(2'b10, 4, 6'b000100, 7'h3F);
        add(2'b10, 4, 6'b001000, 7'h3F);
        add(2'b00, 2, 6'b001000, 7'h3F);
        add(2'b00, 1, 6'b001000, 7'h30);
        add(2'b00, 100, 6'b001000, 7'h30);
        add(2'b10, 2, 6'b001000, 7'h30);
        add(2'b10, 1, 6'b001000, 7'h3F);
        add(2'b10, 4, 6'b010000, 7'h3F);
        add(2'b10, 4, 6'b100000, 7'h3F);
        add(2'b10, 4, 6'b000001, 7'h3F);
        add(2'b10, 4, 6'b000010, 7'h3F);
        // Decel where the release coincides with a step
        add(2'b11, 1, 6'b000010, 7'h3F);
        add(2'b01, 3, 6'b000100, 7'h3F);
        add(2'b01, 3, 6'b000100, 7'h3F);
        add(2'b01, 1, 6'b001000, 7'h3F);
        add(2'b01, 5, 6'b001000, 7'h3F);
        add(2'b01, 1, 6'b010000, 7'h3F);
        add(2'b01, 7, 6'b010000, 7'h3F);
        add(2'b01, 1, 6'b100000, 7'h3F);
        add(2'b01, 9, 6'b100000, 7'h3F);
        add(2'b01, 1, 6'b000001, 7'h40);
        add(2'b01, 20, 6'b000001, 7'h40);
        // Run toggled during decel must be ignored
        add(2'b11, 3, 6'b000001, 7'h3F);
        add(2'b01, 3, 6'b000001, 7'h3F);
        add(2'b11, 2, 6'b000001, 7'h3F);
        add(2'b01, 2, 6'b000010, 7'h3F);
        add(2'b11, 3, 6'b000010, 7'h3F);
        add(2'b01, 3, 6'b000100, 7'h3F);
        add(2'b11, 8, 6'b001000, 7'h3F);
        add(2'b10, 10, 6'b010000, 7'h19);
        add(2'b00, 5, 6'b010000, 7'h19);
        add(2'b10, 2, 6'b010000, 7'h19);
        add(2'b10, 1, 6'b010000, 7'h3F);
        add(2'b10, 4, 6'b100000, 7'h3F);

        nrst = 1'b0; nrst_j = 1'b0; sw = 2'b00; sw_j = 2'b00;
        tick(3);
        chk("reset_led", int'(led), 0);
        chk("reset_hex", int'(hex), 'h7F);
        nrst = 1'b1;
        tick(2);
        chk("idle_led", int'(led), 0);
        chk("idle_hex", int'(hex), 'h7F);

        for (int i = 0; i < vq.size(); i++) begin
            sw = vq[i].sw;
            tick(vq[i].ticks);
            chk($sformatf("vec%0d_led", i), int'(led), int'(vq[i].led));
            chk($sformatf("vec%0d_hex", i), int'(hex), int'(vq[i].hex));
        end

        // Asynchronous reset mid-decel, then run held high across release
        sw = 2'b01;
        tick(3);
        chk("rst_decel_entry_led", int'(led), int'(6'b100000));
        tick(4);
        chk("rst_decel_step_led", int'(led), int'(6'b000001));
        tick(1);
        #3 nrst = 1'b0;
        #1;
        chk("async_rst_led", int'(led), 0);
        chk("async_rst_hex", int'(hex), 'h7F);
        sw = 2'b11;
        @(posedge clk);
        #1;
        chk("rst_held_led", int'(led), 0);
        nrst = 1'b1;
        tick(2);
        chk("rst_rel2_led", int'(led), 0);
        chk("rst_rel2_hex", int'(hex), 'h7F);
        tick(1);
        chk("rst_rel3_led", int'(led), 1);
        chk("rst_rel3_hex", int'(hex), 'h3F);

        // Randomized runs on both instances with shared switches
        nrst = 1'b0; nrst_j = 1'b0; sw = 2'b00; sw_j = 2'b00;
        tick(2);
        nrst = 1'b1; nrst_j = 1'b1;
        tick(3);
        chk("rand_idle_led_j", int'(led_j), 0);
        chk("rand_idle_hex_j", int'(hex_j), 'h7F);
        ps[0] = 0; ps[1] = 0;

        for (int r = 0; r < 200; r++) begin
            logic md;
            int   w;
            int   pos[2], last[2], gprev[2], nst[2];
            bit   done[2];

            md = 1'($urandom_range(0, 1));
            w  = int'($urandom_range(0, 30));
            sw = {1'b1, md}; sw_j = {1'b1, md};
            tick(3);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("r%0d_k%0d_spin_led", r, k), int'(get_led(k)), int'(oh(ps[k])));
                chk($sformatf("r%0d_k%0d_spin_hex", r, k), int'(get_hex(k)), 'h3F);
            end
            tick(w);
            sw = {1'b0, md}; sw_j = {1'b0, md};
            tick(3);
            for (int k = 0; k < 2; k++) begin
                pos[k] = (ps[k] + (w + 3) / STEP) % N;
                chk($sformatf("r%0d_k%0d_rel_led", r, k), int'(get_led(k)), int'(oh(pos[k])));
                last[k] = 0; gprev[k] = 0; nst[k] = 0; done[k] = 1'b0;
            end
            if (!md) begin
                tick(5);
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("r%0d_k%0d_stop_hex", r, k), int'(get_hex(k)), int'(glyph(pos[k])));
                    chk($sformatf("r%0d_k%0d_stop_led", r, k), int'(get_led(k)), int'(oh(pos[k])));
                    ps[k] = pos[k];
                end
            end else begin
                for (int t = 1; t <= 200 && !(done[0] && done[1]); t++) begin
                    tick(1);
                    for (int k = 0; k < 2; k++) begin
                        if (!done[k]) begin
                            if (get_led(k) != oh(pos[k])) begin
                                int g;
                                g = t - last[k];
                                if (nst[k] == 0) begin
                                    chk($sformatf("r%0d_k%0d_gap0", r, k), g, STEP);
                                end else if (k == 0) begin
                                    if (nst[0] < mgap.size())
                                        chk($sformatf("r%0d_gap%0d", r, nst[0]), g, mgap[nst[0]]);
                                    else
                                        chk($sformatf("r%0d_extra_step", r), nst[0], mgap.size());
                                end else begin
                                    chk($sformatf("r%0d_jgap%0d_lo", r, nst[1]), int'(g >= gprev[1] + DEC), 1);
                                    chk($sformatf("r%0d_jgap%0d_hi", r, nst[1]), int'(g <= gprev[1] + DEC + 255), 1);
                                    chk($sformatf("r%0d_jgap%0d_lt_stop", r, nst[1]), int'(g < STOP), 1);
                                end
                                pos[k]   = (pos[k] + 1) % N;
                                nst[k]   = nst[k] + 1;
                                gprev[k] = g;
                                last[k]  = t;
                                chk($sformatf("r%0d_k%0d_decel_led", r, k), int'(get_led(k)), int'(oh(pos[k])));
                            end
                            if (get_hex(k) != 7'h3F) begin
                                done[k] = 1'b1;
                                chk($sformatf("r%0d_k%0d_show_hex", r, k), int'(get_hex(k)), int'(glyph(pos[k])));
                                if (k == 0)
                                    chk($sformatf("r%0d_steps", r), nst[0], mgap.size());
                                else
                                    chk($sformatf("r%0d_jsteps_range", r), int'(nst[1] >= 1 && nst[1] <= 4), 1);
                            end
                        end
                    end
                end
                for (int k = 0; k < 2; k++) begin
                    if (!done[k]) chk($sformatf("r%0d_k%0d_decel_timeout", r, k), 0, 1);
                    ps[k] = pos[k];
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
